lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX-stage instruction valid.
- lsu_ctrl  in  lsuCtrl_e  LSU_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW.
- mem_wr_en  in  1  1 = store, 0 = load.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall_o  out  1  hold upstream pipeline.
- rdata_o  out  32  extended load result.
- rdata_valid_o  out  1  rdata_o valid (1-cycle pulse).
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word address, bits[1:0]=0.
- dmem_wdata  out  32  lane-replicated write data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- misalign_o  out  1  misaligned-access pulse (LSU_MISALIGN_TRAP_EN only).
- misalign_addr_o  out  32  faulting address (LSU_MISALIGN_TRAP_EN only).

Function
REQ-002 FSM states: IDLE, REQ, WAIT, DONE.
REQ-003 IDLE: valid_i=1 and lsu_ctrl!=LSU_NOP -> capture addr, wdata, lsu_ctrl, mem_wr_en into registers; go to REQ. stall_o=1 combinationally in that cycle.
REQ-004 REQ: dmem_req=1, with bus outputs driven from the captured registers and held stable until dmem_gnt. On gnt: store -> DONE, load -> WAIT.
REQ-005 WAIT: on dmem_rvalid, register the extended result into rdata_o -> DONE.
REQ-006 DONE: stall_o=0; rdata_valid_o=1 for loads only; valid_i ignored; unconditional -> IDLE.
REQ-007 stall_o=1 in REQ and WAIT, and in IDLE per REQ-003; otherwise 0.
REQ-008 Minimum latency: store 3 cycles IDLE->DONE; load 4 cycles IDLE->DONE.
REQ-009 Byte enables by access size:
- byte: dmem_be = 4'b0001 << addr[1:0]
- half: dmem_be = 4'b0011 << {addr[1],1'b0}
- word: dmem_be = 4'b1111
REQ-010 dmem_wdata replication: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-011 Load result: shift dmem_rdata right by 8*offset, then LB/LH sign-extend and LBU/LHU zero-extend to 32 bits.
REQ-012 dmem_gnt outside REQ and dmem_rvalid outside WAIT SHALL be ignored.
REQ-013 dmem_rvalid arriving in the same cycle as gnt SHALL NOT complete the load; data is accepted only in WAIT.

Reset
REQ-014 rst_n low asynchronously forces state IDLE.
REQ-015 During reset all outputs are 0, including rdata_o and the captured registers.
REQ-016 Reset mid-transaction drops dmem_req immediately; no completion pulse follows reset release.

Configuration
REQ-017 Feature macro: LSU_MISALIGN_TRAP_EN.
REQ-018 Defined: a misaligned half/word access (half with addr[0]=1; word with addr[1:0]!=0) issues no bus request.
- path IDLE -> DONE.
- in DONE: misalign_o=1 and misalign_addr_o = captured addr; rdata_valid_o=0.
REQ-019 Undefined: misalign ports absent; address forced aligned (half: addr[0]=0; word: addr[1:0]=0); access proceeds normally.

Structure
REQ-020 lsuCtrl_e stays in the shared types package; new lsuState_e is added to the same package.
REQ-021 One sub-module, lsu_load_align: combinational extract and extend of dmem_rdata.

Verification
REQ-022 LW addr=0x104, gnt on REQ cycle 1, rvalid 2 cycles later, rdata=0xDEADBEEF -> dmem_addr=0x104, be=1111, rdata_o=0xDEADBEEF, rdata_valid_o pulses once.
REQ-023 LB addr=0x203, rdata=0x80112233 -> be=1000, rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-024 SH addr=0x302, wdata=0x0000ABCD, gnt delayed 3 cycles -> be=1100, dmem_wdata=0xABCDABCD, stall_o high 5 cycles, rdata_valid_o stays 0.
REQ-025 rst_n low while in WAIT -> dmem_req=0 and stall_o=0 immediately; a late rvalid after release is ignored.
REQ-026 LSU_MISALIGN_TRAP_EN, LW addr=0x101 -> no dmem_req, misalign_o=1, misalign_addr_o=0x101; without macro -> dmem_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   lsuCtrl_e   - decoded memory operation coming from the EX stage
//   lsuState_e  - LSU sequencing states
//   lsu_size_e  - access width derived from lsuCtrl_e
// Helpers: lsu_size() maps an operation to its width; lsu_be() builds
// byte enables from width and byte offset.
package lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NOP,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsuCtrl_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsuState_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  function automatic lsu_size_e lsu_size(lsuCtrl_e ctrl);
    case (ctrl)
      LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
      LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(lsu_size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
//   dmem_req/dmem_gnt      - request handshake
//   dmem_we, dmem_be       - write flag and byte enables
//   dmem_addr, dmem_wdata  - word address and lane-replicated write data
//   dmem_rvalid/dmem_rdata - load response
interface lsu_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the returned word down by the byte
// offset and sign- or zero-extends according to the load type.
//   rdata  in  32  raw bus word
//   offset in  2   byte offset of the access
//   ctrl   in      load operation (LB/LH/LW/LBU/LHU)
//   result out 32  extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  lsuCtrl_e    ctrl,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (ctrl)
      LSU_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      LSU_LBU: result = {24'h0, shifted[7:0]};
      LSU_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      LSU_LHU: result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: sequences one memory access per EX-stage instruction
// over the dmem bus and stalls the pipeline until it completes.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   valid_i         EX instruction valid
//   lsu_ctrl        operation (LSU_NOP = no access)
//   mem_wr_en       1 = store, 0 = load
//   addr, wdata     byte address and store data
//   stall_o         hold upstream pipeline
//   rdata_o         extended load result (held until next load)
//   rdata_valid_o   one-cycle pulse when a load completes
//   bus             lsu_if.master data-memory bus
//   misalign_o, misalign_addr_o  (only with LSU_MISALIGN_TRAP_EN)
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the
// bus and report a trap in DONE. Without it, such addresses are silently
// aligned down to the access size.
//
// state | meaning
// IDLE  | waiting for a valid access; captures operands on start
// REQ   | dmem_req held with stable bus fields until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// DONE  | one-cycle completion: stall released, load result valid
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  lsuCtrl_e    lsu_ctrl,
  input  logic        mem_wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  lsu_if.master       bus
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
`endif
);

  lsuState_e   state_q, state_d;
  lsuCtrl_e    ctrl_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] load_res;

  logic        start;
  lsu_size_e   size_in;
  lsu_size_e   size_q;
  logic [31:0] addr_in;
  logic        mis_in;

  assign start   = valid_i && (lsu_ctrl != LSU_NOP);
  assign size_in = lsu_size(lsu_ctrl);
  assign size_q  = lsu_size(ctrl_q);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  assign addr_in = addr;
  assign mis_in  = ((size_in == SZ_HALF) && addr[0]) ||
                   ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  // Misaligned half/word addresses are rounded down to the access size.
  always_comb begin
    case (size_in)
      SZ_HALF: addr_in = {addr[31:1], 1'b0};
      SZ_WORD: addr_in = {addr[31:2], 2'b00};
      default: addr_in = addr;
    endcase
  end
  assign mis_in = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata  (bus.dmem_rdata),
    .offset (addr_q[1:0]),
    .ctrl   (ctrl_q),
    .result (load_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      ctrl_q  <= LSU_NOP;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == LSU_IDLE && start) begin
        ctrl_q  <= lsu_ctrl;
        we_q    <= mem_wr_en;
        addr_q  <= addr_in;
        wdata_q <= wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q   <= mis_in;
`endif
      end
      if (state_q == LSU_WAIT && bus.dmem_rvalid) begin
        rdata_q <= load_res;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    rdata_valid_o  = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_be    = 4'h0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_o      = 1'b0;
    misalign_addr_o = 32'h0;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          state_d = mis_in ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        stall_o        = 1'b1;
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = we_q;
        bus.dmem_be    = lsu_be(size_q, addr_q[1:0]);
        bus.dmem_addr  = {addr_q[31:2], 2'b00};
        case (size_q)
          SZ_BYTE: bus.dmem_wdata = {4{wdata_q[7:0]}};
          SZ_HALF: bus.dmem_wdata = {2{wdata_q[15:0]}};
          default: bus.dmem_wdata = wdata_q;
        endcase
        if (bus.dmem_gnt) begin
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        stall_o = 1'b1;
        if (bus.dmem_rvalid) begin
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        rdata_valid_o   = !we_q && !mis_q;
        misalign_o      = mis_q;
        misalign_addr_o = mis_q ? addr_q : 32'h0;
`else
        rdata_valid_o   = !we_q;
`endif
      end
      default: state_d = LSU_IDLE;
    endcase
    // The IDLE stall term follows live inputs; keep it quiet while in reset.
    if (!rst_n) begin
      stall_o = 1'b0;
    end
  end

  assign rdata_o = rdata_q;

endmodule
